// File: rtl/memory_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : memory_access_unit
// Brief    : RISC-V load/store initiator for a word-addressed data RAM, with
//            read-modify-write sub-word stores and misalignment/range faults.
// Revision : 1.0
// ============================================================================
module memory_access_unit #(
  parameter int SIZE_WORDS = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_address,
  input  logic [31:0] req_write_data,
  input  logic [2:0]  req_funct3,
  input  logic        req_is_store,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_read_data,
  output logic        resp_misaligned,
  output logic        resp_fault,
  output logic [31:0] mem_address,
  output logic [31:0] mem_input_data,
  output logic        mem_should_write,
  input  logic [31:0] mem_output_data
);

  localparam logic [1:0]  c_IDLE        = 2'd0;
  localparam logic [1:0]  c_ACCESS      = 2'd1;
  localparam logic [1:0]  c_WRITE       = 2'd2;
  localparam logic [1:0]  c_RESP        = 2'd3;
  localparam logic [31:0] c_LIMIT_BYTES = 32'(SIZE_WORDS * 4);

  logic [1:0]  state_q, state_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        is_store_q, is_store_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [31:0] mem_input_data_q, mem_input_data_d;
  logic [31:0] resp_read_data_q, resp_read_data_d;
  logic        resp_misaligned_q, resp_misaligned_d;
  logic        resp_fault_q, resp_fault_d;

  logic        w_misaligned;
  logic        w_illegal;
  logic        w_fault;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [31:0] w_merged;
  logic        w_full_word_store;

  // Request checks evaluated on the raw request so faults skip the RAM entirely
  always_comb begin
    w_misaligned = 1'b0;
    case (req_funct3[1:0])
      2'b01:   w_misaligned = req_address[0];
      2'b10:   w_misaligned = |req_address[1:0];
      default: w_misaligned = 1'b0;
    endcase
    w_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                (req_funct3[2] && req_is_store);
    w_fault   = w_illegal || (req_address >= c_LIMIT_BYTES);
  end

  always_comb begin
    w_byte      = mem_output_data[{lane_q, 3'b000} +: 8];
    w_half      = lane_q[1] ? mem_output_data[31:16] : mem_output_data[15:0];
    w_load_data = mem_output_data;
    case (funct3_q[1:0])
      2'b00:   w_load_data = {{24{~funct3_q[2] & w_byte[7]}}, w_byte};
      2'b01:   w_load_data = {{16{~funct3_q[2] & w_half[15]}}, w_half};
      default: w_load_data = mem_output_data;
    endcase
  end

  always_comb begin
    w_merged = mem_output_data;
    if (funct3_q[1:0] == 2'b00) begin
      w_merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      w_merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
    end
  end

  assign w_full_word_store = is_store_q && (funct3_q[1:0] == 2'b10);

  always_comb begin
    state_d           = state_q;
    lane_d            = lane_q;
    wdata_d           = wdata_q;
    funct3_d          = funct3_q;
    is_store_d        = is_store_q;
    mem_address_d     = mem_address_q;
    mem_input_data_d  = mem_input_data_q;
    resp_read_data_d  = resp_read_data_q;
    resp_misaligned_d = resp_misaligned_q;
    resp_fault_d      = resp_fault_q;
    case (state_q)
      c_IDLE: begin
        if (req_valid) begin
          lane_d            = req_address[1:0];
          wdata_d           = req_write_data[15:0];
          funct3_d          = req_funct3;
          is_store_d        = req_is_store;
          resp_read_data_d  = 32'd0;
          resp_misaligned_d = w_misaligned;
          resp_fault_d      = w_fault;
          if (w_misaligned || w_fault) begin
            state_d = c_RESP;
          end else begin
            state_d       = c_ACCESS;
            mem_address_d = {req_address[31:2], 2'b00};
            // Full-word store data must already be on the bus during ACCESS
            if (req_is_store && (req_funct3[1:0] == 2'b10)) begin
              mem_input_data_d = req_write_data;
            end
          end
        end
      end
      c_ACCESS: begin
        if (!is_store_q) begin
          resp_read_data_d = w_load_data;
          state_d          = c_RESP;
        end else if (w_full_word_store) begin
          state_d = c_RESP;
        end else begin
          mem_input_data_d = w_merged;
          state_d          = c_WRITE;
        end
      end
      c_WRITE: begin
        state_d = c_RESP;
      end
      c_RESP: begin
        if (resp_ready) begin
          state_d           = c_IDLE;
          resp_read_data_d  = 32'd0;
          resp_misaligned_d = 1'b0;
          resp_fault_d      = 1'b0;
        end
      end
      default: begin
        state_d = c_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q           <= c_IDLE;
      lane_q            <= 2'd0;
      wdata_q           <= 16'd0;
      funct3_q          <= 3'd0;
      is_store_q        <= 1'b0;
      mem_address_q     <= 32'd0;
      mem_input_data_q  <= 32'd0;
      resp_read_data_q  <= 32'd0;
      resp_misaligned_q <= 1'b0;
      resp_fault_q      <= 1'b0;
    end else begin
      state_q           <= state_d;
      lane_q            <= lane_d;
      wdata_q           <= wdata_d;
      funct3_q          <= funct3_d;
      is_store_q        <= is_store_d;
      mem_address_q     <= mem_address_d;
      mem_input_data_q  <= mem_input_data_d;
      resp_read_data_q  <= resp_read_data_d;
      resp_misaligned_q <= resp_misaligned_d;
      resp_fault_q      <= resp_fault_d;
    end
  end

  assign req_ready       = (state_q == c_IDLE);
  assign resp_valid      = (state_q == c_RESP);
  assign resp_read_data  = resp_read_data_q;
  assign resp_misaligned = resp_misaligned_q;
  assign resp_fault      = resp_fault_q;
  assign mem_address     = mem_address_q;
  assign mem_input_data  = mem_input_data_q;

  // Gated by reset so an in-flight write is dropped in the very cycle reset rises
  assign mem_should_write = !reset &&
                            (((state_q == c_ACCESS) && w_full_word_store) ||
                             (state_q == c_WRITE));

endmodule
`default_nettype wire

// File: tb/tb_memory_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_access_unit
// Brief    : Scoreboard bench for memory_access_unit with a negedge-commit RAM.
// Revision : 1.0
// ============================================================================
module tb_memory_access_unit;

  localparam int SIZE_WORDS = 64;

  typedef struct packed {
    logic [31:0] data;
    logic        mis;
    logic        flt;
  } resp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  f3;
    logic        st;
    logic [31:0] e_data;
    logic        e_mis;
    logic        e_flt;
    int          e_lat;
    int          e_pulses;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_address;
  logic [31:0] req_write_data;
  logic [2:0]  req_funct3;
  logic        req_is_store;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_read_data;
  logic        resp_misaligned;
  logic        resp_fault;
  logic [31:0] mem_address;
  logic [31:0] mem_input_data;
  logic        mem_should_write;
  logic [31:0] mem_output_data;

  logic [31:0] ram [SIZE_WORDS];
  resp_t       sb_q[$];
  resp_t       obs_q[$];
  int          wr_count = 0;
  logic [31:0] last_wr_addr = 32'd0;
  int          errors = 0;
  int          checks = 0;

  memory_access_unit #(.SIZE_WORDS(SIZE_WORDS)) dut (
    .clock            (clock),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_address      (req_address),
    .req_write_data   (req_write_data),
    .req_funct3       (req_funct3),
    .req_is_store     (req_is_store),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_read_data   (resp_read_data),
    .resp_misaligned  (resp_misaligned),
    .resp_fault       (resp_fault),
    .mem_address      (mem_address),
    .mem_input_data   (mem_input_data),
    .mem_should_write (mem_should_write),
    .mem_output_data  (mem_output_data)
  );

  always #5 clock = ~clock;

  assign mem_output_data = ram[mem_address[7:2]];

  // RAM commit, write-pulse tally and response capture all happen mid-cycle
  always @(negedge clock) begin
    if (mem_should_write) begin
      ram[mem_address[7:2]] <= mem_input_data;
      wr_count     = wr_count + 1;
      last_wr_addr = mem_address;
    end
    if (!reset && resp_valid && resp_ready) begin
      obs_q.push_back({resp_read_data, resp_misaligned, resp_fault});
    end
  end

  task automatic issue(input vec_t v, output int lat, output int pulses,
                       output logic [31:0] paddr, output resp_t obs);
    int w0;
    w0 = wr_count;
    sb_q.push_back({v.e_data, v.e_mis, v.e_flt});
    req_valid      = 1'b1;
    req_address    = v.a;
    req_write_data = v.d;
    req_funct3     = v.f3;
    req_is_store   = v.st;
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    @(posedge clock); #1;
    pulses = wr_count - w0;
    paddr  = last_wr_addr;
    if (obs_q.size() > 0) obs = obs_q.pop_front();
    else obs = '1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_should_write !== 1'b0)
      begin errors++; $display("FAIL reset_handshake: ready=%b valid=%b we=%b, need 1 0 0", req_ready, resp_valid, mem_should_write); end
    checks++;
    if ({resp_read_data, resp_misaligned, resp_fault} !== 34'd0)
      begin errors++; $display("FAIL reset_resp: data=%h mis=%b flt=%b, need 0", resp_read_data, resp_misaligned, resp_fault); end
    checks++;
    if (mem_address !== 32'd0 || mem_input_data !== 32'd0)
      begin errors++; $display("FAIL reset_mem: addr=%h wdata=%h, need 0 0", mem_address, mem_input_data); end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_store_word();
    vec_t v; int lat; int pulses; logic [31:0] paddr; resp_t obs; resp_t exp;
    v = '{32'h08, 32'hDEADBEEF, 3'b010, 1'b1, 32'h0, 1'b0, 1'b0, 2, 1};
    issue(v, lat, pulses, paddr, obs);
    exp = sb_q.pop_front();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL sw_resp: got %h, need %h", obs, exp); end
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL sw_latency: got %0d, need 2", lat); end
    checks++;
    if (pulses !== 1 || paddr !== 32'h08)
      begin errors++; $display("FAIL sw_pulse: count=%0d addr=%h, need 1 at 00000008", pulses, paddr); end
    checks++;
    if (ram[2] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_ram: word2=%h, need deadbeef", ram[2]); end
  endtask

  task automatic test_loads();
    vec_t v[5]; int lat; int pulses; logic [31:0] paddr; resp_t obs; resp_t exp;
    v[0] = '{32'h0B, 32'h0, 3'b000, 1'b0, 32'hFFFFFFDE, 1'b0, 1'b0, 2, 0};
    v[1] = '{32'h0B, 32'h0, 3'b100, 1'b0, 32'h000000DE, 1'b0, 1'b0, 2, 0};
    v[2] = '{32'h08, 32'h0, 3'b001, 1'b0, 32'hFFFFBEEF, 1'b0, 1'b0, 2, 0};
    v[3] = '{32'h0A, 32'h0, 3'b101, 1'b0, 32'h0000DEAD, 1'b0, 1'b0, 2, 0};
    v[4] = '{32'h08, 32'h0, 3'b010, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 2, 0};
    for (int i = 0; i < 5; i++) begin
      issue(v[i], lat, pulses, paddr, obs);
      exp = sb_q.pop_front();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL load%0d_resp: got %h, need %h", i, obs, exp); end
      checks++;
      if (lat !== v[i].e_lat || pulses !== v[i].e_pulses)
        begin errors++; $display("FAIL load%0d_timing: lat=%0d pulses=%0d, need %0d %0d", i, lat, pulses, v[i].e_lat, v[i].e_pulses); end
    end
  endtask

  task automatic test_backpressure();
    resp_t obs; resp_t exp; int lat; int w0; logic [31:0] word3;
    w0    = wr_count;
    word3 = ram[3];
    sb_q.push_back({32'hDEADBEEF, 1'b0, 1'b0});
    resp_ready     = 1'b0;
    req_valid      = 1'b1;
    req_address    = 32'h08;
    req_funct3     = 3'b010;
    req_is_store   = 1'b0;
    req_write_data = 32'h0;
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL bp_latency: got %0d, need 2", lat); end
    // A competing store is presented for the whole stall
    req_valid      = 1'b1;
    req_address    = 32'h0C;
    req_write_data = 32'h00000055;
    req_funct3     = 3'b010;
    req_is_store   = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clock); #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_read_data !== 32'hDEADBEEF || req_ready !== 1'b0)
        begin errors++; $display("FAIL bp_hold%0d: valid=%b data=%h ready=%b, need 1 deadbeef 0", c, resp_valid, resp_read_data, req_ready); end
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1)
      begin errors++; $display("FAIL bp_release: valid=%b ready=%b, need 0 1", resp_valid, req_ready); end
    checks++;
    if (wr_count !== w0 || ram[3] !== word3)
      begin errors++; $display("FAIL bp_ignored: pulses=%0d word3=%h, need 0 %h", wr_count - w0, ram[3], word3); end
    exp = sb_q.pop_front();
    obs = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL bp_resp: got %h, need %h", obs, exp); end
  endtask

  task automatic test_subword_stores();
    vec_t v[2]; logic [31:0] want[2]; int lat; int pulses; logic [31:0] paddr; resp_t obs; resp_t exp;
    v[0] = '{32'h09, 32'h12345677, 3'b000, 1'b1, 32'h0, 1'b0, 1'b0, 3, 1};
    v[1] = '{32'h0A, 32'hAAAA5555, 3'b001, 1'b1, 32'h0, 1'b0, 1'b0, 3, 1};
    want[0] = 32'hDEAD77EF;
    want[1] = 32'h555577EF;
    for (int i = 0; i < 2; i++) begin
      issue(v[i], lat, pulses, paddr, obs);
      exp = sb_q.pop_front();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL sub%0d_resp: got %h, need %h", i, obs, exp); end
      checks++;
      if (lat !== 3 || pulses !== 1 || paddr !== 32'h08)
        begin errors++; $display("FAIL sub%0d_timing: lat=%0d pulses=%0d addr=%h, need 3 1 00000008", i, lat, pulses, paddr); end
      checks++;
      if (ram[2] !== want[i]) begin errors++; $display("FAIL sub%0d_ram: word2=%h, need %h", i, ram[2], want[i]); end
    end
  endtask

  task automatic test_faults();
    vec_t v[3]; int lat; int pulses; logic [31:0] paddr; resp_t obs; resp_t exp;
    v[0] = '{32'h06,  32'h0,        3'b010, 1'b0, 32'h0, 1'b1, 1'b0, 1, 0};
    v[1] = '{32'h100, 32'h01020304, 3'b010, 1'b1, 32'h0, 1'b0, 1'b1, 1, 0};
    v[2] = '{32'h08,  32'h0,        3'b011, 1'b0, 32'h0, 1'b0, 1'b1, 1, 0};
    for (int i = 0; i < 3; i++) begin
      issue(v[i], lat, pulses, paddr, obs);
      exp = sb_q.pop_front();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL fault%0d_resp: got %h, need %h", i, obs, exp); end
      checks++;
      if (lat !== 1 || pulses !== 0)
        begin errors++; $display("FAIL fault%0d_timing: lat=%0d pulses=%0d, need 1 0", i, lat, pulses); end
    end
    checks++;
    if (ram[2] !== 32'h555577EF) begin errors++; $display("FAIL fault_ram: word2=%h, need 555577ef", ram[2]); end
  endtask

  task automatic test_reset_during_write();
    vec_t v; int lat; int pulses; logic [31:0] paddr; resp_t obs; resp_t exp; int w0;
    v = '{32'h04, 32'h11223344, 3'b010, 1'b1, 32'h0, 1'b0, 1'b0, 2, 1};
    issue(v, lat, pulses, paddr, obs);
    exp = sb_q.pop_front();
    checks++;
    if (obs !== exp || ram[1] !== 32'h11223344)
      begin errors++; $display("FAIL rst_setup: resp=%h word1=%h, need %h 11223344", obs, ram[1], exp); end
    w0 = wr_count;
    req_valid      = 1'b1;
    req_address    = 32'h04;
    req_write_data = 32'h000000AB;
    req_funct3     = 3'b000;
    req_is_store   = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    checks++;
    if (mem_should_write !== 1'b0) begin errors++; $display("FAIL rst_write_strobe: we=%b, need 0", mem_should_write); end
    @(posedge clock); #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_should_write !== 1'b0 ||
        mem_address !== 32'd0 || mem_input_data !== 32'd0 ||
        {resp_read_data, resp_misaligned, resp_fault} !== 34'd0)
      begin errors++; $display("FAIL rst_outputs: ready=%b valid=%b we=%b addr=%h wdata=%h data=%h, need reset values", req_ready, resp_valid, mem_should_write, mem_address, mem_input_data, resp_read_data); end
    checks++;
    if (wr_count !== w0 || ram[1] !== 32'h11223344)
      begin errors++; $display("FAIL rst_ram: pulses=%0d word1=%h, need 0 11223344", wr_count - w0, ram[1]); end
    reset = 1'b0;
    @(posedge clock); #1;
    v = '{32'h04, 32'h0, 3'b010, 1'b0, 32'h11223344, 1'b0, 1'b0, 2, 0};
    issue(v, lat, pulses, paddr, obs);
    exp = sb_q.pop_front();
    checks++;
    if (obs !== exp || lat !== 2) begin errors++; $display("FAIL rst_recover: resp=%h lat=%0d, need %h 2", obs, lat, exp); end
  endtask

  initial begin
    req_valid      = 1'b0;
    req_address    = 32'd0;
    req_write_data = 32'd0;
    req_funct3     = 3'd0;
    req_is_store   = 1'b0;
    resp_ready     = 1'b1;
    test_reset();
    test_store_word();
    test_loads();
    test_backpressure();
    test_subword_stores();
    test_faults();
    test_reset_during_write();
    checks++;
    if (sb_q.size() !== 0 || obs_q.size() !== 0)
      begin errors++; $display("FAIL scoreboard_drain: expected=%0d observed=%0d left, need 0 0", sb_q.size(), obs_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units, need completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/memory_access_unit.md
Name: memory_access_unit

Overview:
- Initiator side of the word-addressed data RAM port: the RAM decodes address/data/should_write, and this block generates them from CPU load/store requests.
- Accepts one RISC-V load or store at a time (LB/LH/LW/LBU/LHU/SB/SH/SW) over a valid/ready request handshake.
- Sub-word stores are done as read-modify-write.
- Returns sign- or zero-extended load data over a valid/ready response handshake, with misalignment and range faults.

Parameters:
- SIZE_WORDS, 64, number of 32-bit words in the attached RAM. A byte address >= SIZE_WORDS*4 is out of range.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_address  input  32  byte address.
- req_write_data  input  32  store data; the value sits in the low bits for SB/SH.
- req_funct3  input  3  RISC-V size/sign code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- req_is_store  input  1  1 = store, 0 = load.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts the response.
- resp_read_data  output  32  extended load data; 0 for stores and faults.
- resp_misaligned  output  1  address not aligned to the access size.
- resp_fault  output  1  out of range, or illegal funct3 (011, 11x, or 1xx with store).
- mem_address  output  32  word-aligned byte address to RAM.
- mem_input_data  output  32  word to write.
- mem_should_write  output  1  write strobe; the RAM commits on the following negedge.
- mem_output_data  input  32  combinational RAM read of mem_address.

Behaviour:
- Reset values:
  - State IDLE.
  - req_ready=1.
  - resp_valid=0, resp_read_data=0, resp_misaligned=0, resp_fault=0.
  - mem_should_write=0, mem_address=0, mem_input_data=0.
  - All internal request registers cleared.
  - Reset mid-operation aborts the access. A write in progress is suppressed from the reset cycle on, because mem_should_write is 0 while reset is high.
- States: IDLE, ACCESS, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, capture address, data, funct3, is_store and go to ACCESS.
  - Fault/misalignment check is done at capture. If it fails, go directly to RESP with the flag set and no RAM access.
  - Misaligned means: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - If both fault and misaligned apply, set both flags.
- ACCESS:
  - mem_address = {addr[31:2],2'b00}.
  - Load: latch the extracted and extended lane of mem_output_data, then go to RESP.
    - Byte lane = addr[1:0]; halfword lane = addr[1].
    - LB/LH sign-extend; LBU/LHU zero-extend.
  - SW: mem_should_write=1, mem_input_data=req_write_data, then go to RESP.
  - SB/SH:
    - Latch the merged word: read word with the selected lane replaced by write_data[7:0] or [15:0].
    - mem_should_write=0, then go to WRITE.
- WRITE: mem_address held, mem_input_data=merged word, mem_should_write=1, then go to RESP.
- RESP:
  - resp_valid=1; outputs are stable until the handshake.
  - Leave for IDLE when resp_ready=1.
  - req_ready=0 in every state except IDLE; no new request is accepted in the same cycle as the response handshake.
- Latency from request accept edge to resp_valid:
  - 2 cycles for loads and SW.
  - 3 cycles for SB/SH.
  - 1 cycle for faults.
- mem_should_write is high for exactly one cycle per store and never for loads or faults.
- Outside ACCESS and WRITE, mem_address holds its last value and mem_should_write=0.

Test Plan:
- After reset, all outputs at their reset values and req_ready=1 → SW addr 0x08 data 0xDEADBEEF → exactly one mem_should_write pulse at mem_address 0x08; resp_valid two cycles after accept; RAM word 2 = 0xDEADBEEF.
- With word 2 = 0xDEADBEEF: LB 0x0B → 0xFFFFFFDE; LBU 0x0B → 0x000000DE; LH 0x08 → 0xFFFFBEEF; LHU 0x0A → 0x0000DEAD; LW 0x08 → 0xDEADBEEF.
- SB 0x09 data 0x12345677 → word 2 = 0xDEAD77EF; SH 0x0A data 0xAAAA5555 → word 2 = 0x555577EF; each response arrives 3 cycles after accept.
- Faults:
  - LW 0x06 → resp_misaligned=1, resp_fault=0.
  - SW 0x100 with SIZE_WORDS=64 → resp_fault=1.
  - funct3=011 → resp_fault=1.
  - In all three, no mem_should_write pulse and resp_valid one cycle after accept.
- Backpressure: hold resp_ready=0 for 5 cycles during a load → resp_valid and resp_read_data stable and req_ready=0 throughout; a second req_valid is ignored until the handshake completes.
- Assert reset in the WRITE cycle of SB 0x04 → mem_should_write=0 that cycle; word 1 unchanged; all outputs at reset values on the next cycle.
